// File: rtl/serial_fa_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: streams operand bits LSB-first through an
// external combinational full adder and assembles the sum and final carry-out.
module serial_fa_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic [2:0]       fa_port_input,
  input  logic [1:0]       fa_port_output
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = (res_sh_q >> 1) | (WIDTH'(fa_port_output[0]) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // fa_port_output is only consumed in S_RUN, so X from the adder elsewhere is harmless.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = op_a;
          b_sh_d   = op_b;
          carry_d  = cin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        res_sh_d = res_next;
        carry_d  = fa_port_output[1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = res_next;
          cout_d  = fa_port_output[1];
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q == S_RUN);
    fa_port_input = 3'b000;
    if (state_q == S_RUN) fa_port_input = {a_sh_q[0], b_sh_q[0], carry_q};
  end

  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_fa_adder_ctrl.sv
// Bench for serial_fa_adder_ctrl: arithmetic reference model checked every cycle on
// the 8-bit build, plus directed literal checks on 8-bit and 1-bit builds.
module tb_serial_fa_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout_out;
  logic [7:0] sum_out;
  logic [2:0] fa_in;
  logic [1:0] fa_out;

  logic       start1 = 1'b0;
  logic [0:0] op_a1 = '0, op_b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [2:0] fa_in1;
  logic [1:0] fa_out1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External full adders
  assign fa_out  = {(fa_in[2] & fa_in[1]) | (fa_in[2] & fa_in[0]) | (fa_in[1] & fa_in[0]), ^fa_in};
  assign fa_out1 = {(fa_in1[2] & fa_in1[1]) | (fa_in1[2] & fa_in1[0]) | (fa_in1[1] & fa_in1[0]), ^fa_in1};

  serial_fa_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
    .fa_port_input(fa_in), .fa_port_output(fa_out)
  );

  serial_fa_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1),
    .fa_port_input(fa_in1), .fa_port_output(fa_out1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running bit m_k, 2 reporting
  int         m_phase = 0;
  int         m_k = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic       m_cin = 1'b0;
  logic [7:0] m_sum = '0;
  logic       m_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [8:0] full;
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sum = '0; m_cout = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_a = op_a; m_b = op_b; m_cin = cin; m_k = 0; m_phase = 1;
        end
        1: if (m_k == 7) begin
          full = 9'(m_a) + 9'(m_b) + 9'(m_cin);
          m_sum = full[7:0]; m_cout = full[8]; m_phase = 2;
        end else m_k++;
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [2:0] exp_fa();
    logic [31:0] mask, part;
    if (m_phase != 1) return 3'b000;
    mask = (32'd1 << m_k) - 32'd1;
    part = (32'(m_a) & mask) + (32'(m_b) & mask) + 32'(m_cin);
    return {m_a[m_k], m_b[m_k], part[m_k]};
  endfunction

  always @(negedge clk) begin
    chk("busy",     32'(busy),     32'(m_phase == 1));
    chk("done",     32'(done),     32'(m_phase == 2));
    chk("sum_out",  32'(sum_out),  32'(m_sum));
    chk("cout_out", 32'(cout_out), 32'(m_cout));
    chk("fa_input", 32'(fa_in),    32'(exp_fa()));
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int busy_n, output logic [2:0] fa1, output logic [2:0] fa2);
    bit got = 0;
    busy_n = 0; fa1 = '0; fa2 = '0;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk); #1;
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (busy_n == 1) fa1 = fa_in;
        if (busy_n == 2) fa2 = fa_in;
      end
      if (done) got = 1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int         bn;
    logic [2:0] f1, f2;
    bit         got;

    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum_out), 32'd0);
    chk("rst_fa",   32'(fa_in), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, bn, f1, f2);
    chk("t1_sum", 32'(sum_out), 32'h96);
    chk("t1_cout", 32'(cout_out), 32'd0);
    chk("t1_busy_cycles", 32'(bn), 32'd8);
    chk("t1_fa_first", 32'(f1), 32'b000);

    do_op(8'hFF, 8'h01, 1'b0, bn, f1, f2);
    chk("t2_sum", 32'(sum_out), 32'h00);
    chk("t2_cout", 32'(cout_out), 32'd1);
    chk("t2_fa_second", 32'(f2), 32'b101);

    do_op(8'hFF, 8'hFF, 1'b1, bn, f1, f2);
    chk("t3_sum", 32'(sum_out), 32'hFF);
    chk("t3_cout", 32'(cout_out), 32'd1);
    do_op(8'h00, 8'h00, 1'b0, bn, f1, f2);
    chk("t3b_sum", 32'(sum_out), 32'h00);
    chk("t3b_cout", 32'(cout_out), 32'd0);

    // start held high, operands churning after the accepted edge
    @(posedge clk); #1;
    start = 1'b1; op_a = 8'h11; op_b = 8'h22; cin = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) got = 1;
    end
    chk("t4_got_done", 32'(got), 32'd1);
    chk("t4_sum", 32'(sum_out), 32'h33);
    op_a = 8'h40; op_b = 8'h05; cin = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    start = 1'b0;
    chk("t4b_got_done", 32'(got), 32'd1);
    chk("t4b_sum", 32'(sum_out), 32'h46);
    chk("t4b_cout", 32'(cout_out), 32'd0);

    // reset in RUN cycle 4
    @(posedge clk); #1;
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_sum", 32'(sum_out), 32'd0);
    chk("t5_cout", 32'(cout_out), 32'd0);
    chk("t5_fa", 32'(fa_in), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h12, 8'h34, 1'b0, bn, f1, f2);
    chk("t5b_sum", 32'(sum_out), 32'h46);
    chk("t5b_cout", 32'(cout_out), 32'd0);

    do_op(8'h80, 8'h80, 1'b0, bn, f1, f2);
    chk("t6_sum", 32'(sum_out), 32'h00);
    chk("t6_cout", 32'(cout_out), 32'd1);
    do_op(8'hAA, 8'h54, 1'b1, bn, f1, f2);
    chk("t7_sum", 32'(sum_out), 32'hFF);
    chk("t7_cout", 32'(cout_out), 32'd0);

    // WIDTH=1 build
    @(posedge clk); #1;
    start1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; cin1 = 1'b0;
    chk("w1_busy", 32'(busy1), 32'd1);
    chk("w1_fa", 32'(fa_in1), 32'b111);
    @(posedge clk); #1;
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_busy_off", 32'(busy1), 32'd0);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_cout", 32'(cout1), 32'd1);
    chk("w1_fa_idle", 32'(fa_in1), 32'd0);
    @(posedge clk); #1;
    chk("w1_done_off", 32'(done1), 32'd0);
    chk("w1_sum_hold", 32'(sum1), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
